// File: rtl/bp_fe_bht_updater_pkg.sv
// Shared types for the FE BHT updater: entry declaration macro, update-result enum and a saturating increment.
`define BP_FE_DECLARE_BHT_UPD_ENTRY_S(idx_width_mp) \
  typedef struct packed { \
    logic [idx_width_mp-1:0] idx; \
    logic                    taken; \
  } bp_fe_bht_upd_entry_s

package bp_fe_pkg;

  typedef enum logic {
    e_bht_mispred = 1'b0,
    e_bht_correct = 1'b1
  } bp_fe_bht_upd_result_e;

  localparam logic [31:0] stat_max_lp = 32'hFFFF_FFFF;

  function automatic logic [31:0] sat_inc32(input logic [31:0] val);
    return (val == stat_max_lp) ? val : val + 32'd1;
  endfunction

endpackage

// File: rtl/bp_fe_bht_updater_if.sv
// Fetch-side prediction capture, backend resolution and BHT write-port bundle for bp_fe_bht_updater.
interface bp_fe_bht_updater_if #(
  parameter int bht_idx_width_p = 9,
  parameter int els_p           = 8
);
  logic                       pred_v_i;
  logic [bht_idx_width_p-1:0] pred_idx_i;
  logic                       pred_taken_i;
  logic                       pred_ready_o;
  logic                       res_v_i;
  logic                       res_taken_i;
  logic                       flush_i;
  logic                       w_v_o;
  logic [bht_idx_width_p-1:0] idx_w_o;
  logic                       correct_o;
  logic [$clog2(els_p):0]     count_o;
  logic                       err_o;
  logic [31:0]                stat_correct_o;
  logic [31:0]                stat_mispred_o;

  modport master (
    output pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
    input  pred_ready_o, w_v_o, idx_w_o, correct_o, count_o, err_o,
           stat_correct_o, stat_mispred_o
  );

  modport slave (
    input  pred_v_i, pred_idx_i, pred_taken_i, res_v_i, res_taken_i, flush_i,
    output pred_ready_o, w_v_o, idx_w_o, correct_o, count_o, err_o,
           stat_correct_o, stat_mispred_o
  );
endinterface

// File: rtl/bp_fe_bht_updater_queue.sv
// In-order queue of outstanding BHT predictions; wrap-bit pointers, flush discards everything not yet dequeued.
module bp_fe_bht_upd_queue
  import bp_fe_pkg::*;
#(
  parameter  int bht_idx_width_p = 9,
  parameter  int els_p           = 8,
  localparam int lg_els_lp       = $clog2(els_p)
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       enq_v,
  input  logic [bht_idx_width_p-1:0] enq_idx,
  input  logic                       enq_taken,
  input  logic                       deq_v,
  input  logic                       flush,
  output logic                       enq_ready,
  output logic                       deq_fire,
  output logic                       empty,
  output logic [bht_idx_width_p-1:0] head_idx,
  output logic                       head_taken,
  output logic [lg_els_lp:0]         count
);
  `BP_FE_DECLARE_BHT_UPD_ENTRY_S(bht_idx_width_p);

  localparam logic [lg_els_lp:0] ptr_one_lp = {{lg_els_lp{1'b0}}, 1'b1};

  bp_fe_bht_upd_entry_s     mem [els_p];
  bp_fe_bht_upd_entry_s     head;
  logic [lg_els_lp:0]       rd_ptr, wr_ptr;
  logic                     full, enq_fire;

  assign full      = (rd_ptr[lg_els_lp-1:0] == wr_ptr[lg_els_lp-1:0])
                   && (rd_ptr[lg_els_lp] != wr_ptr[lg_els_lp]);
  assign empty     = (rd_ptr == wr_ptr);
  assign enq_ready = ~full;
  // Readiness comes only from registered pointers, so a full queue ignores a same-cycle dequeue.
  assign enq_fire  = enq_v & ~full & ~flush;
  assign deq_fire  = deq_v & ~empty;
  assign count     = wr_ptr - rd_ptr;

  always_ff @(posedge clk) begin
    if (reset) begin
      rd_ptr <= '0;
      wr_ptr <= '0;
    end else begin
      if (enq_fire) wr_ptr <= wr_ptr + ptr_one_lp;
      if (flush)         rd_ptr <= wr_ptr;
      else if (deq_fire) rd_ptr <= rd_ptr + ptr_one_lp;
    end
  end

  always_ff @(posedge clk) begin
    if (enq_fire) mem[wr_ptr[lg_els_lp-1:0]] <= '{idx: enq_idx, taken: enq_taken};
  end

  assign head       = mem[rd_ptr[lg_els_lp-1:0]];
  assign head_idx   = head.idx;
  assign head_taken = head.taken;
endmodule

// File: rtl/bp_fe_bht_updater.sv
// Pairs queued BHT predictions with backend outcomes and drives the BHT update port one cycle later.
// Optional update statistics are built when BP_FE_BHT_UPDATER_STATS_EN is defined.
module bp_fe_bht_updater
  import bp_fe_pkg::*;
#(
  parameter int bht_idx_width_p = 9,
  parameter int els_p           = 8
) (
  input logic                clk_i,
  input logic                reset_i,
  bp_fe_bht_updater_if.slave bus
);
  logic                       deq_fire, empty;
  logic [bht_idx_width_p-1:0] head_idx, idx_w;
  logic                       head_taken, w_v, correct, err;

  bp_fe_bht_upd_queue #(
    .bht_idx_width_p(bht_idx_width_p),
    .els_p          (els_p)
  ) queue (
    .clk       (clk_i),
    .reset     (reset_i),
    .enq_v     (bus.pred_v_i),
    .enq_idx   (bus.pred_idx_i),
    .enq_taken (bus.pred_taken_i),
    .deq_v     (bus.res_v_i),
    .flush     (bus.flush_i),
    .enq_ready (bus.pred_ready_o),
    .deq_fire  (deq_fire),
    .empty     (empty),
    .head_idx  (head_idx),
    .head_taken(head_taken),
    .count     (bus.count_o)
  );

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      w_v     <= 1'b0;
      idx_w   <= '0;
      correct <= 1'b0;
      err     <= 1'b0;
    end else begin
      w_v <= deq_fire;
      if (deq_fire) begin
        idx_w   <= head_idx;
        correct <= ~(head_taken ^ bus.res_taken_i);
      end
      // A resolution with nothing outstanding means fetch and backend lost sync.
      if (bus.res_v_i && empty) err <= 1'b1;
    end
  end

  assign bus.w_v_o     = w_v;
  assign bus.idx_w_o   = idx_w;
  assign bus.correct_o = correct;
  assign bus.err_o     = err;

`ifdef BP_FE_BHT_UPDATER_STATS_EN
  logic [31:0]           stat_correct, stat_mispred;
  bp_fe_bht_upd_result_e result;

  assign result = correct ? e_bht_correct : e_bht_mispred;

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      stat_correct <= '0;
      stat_mispred <= '0;
    end else if (w_v) begin
      if (result == e_bht_correct) stat_correct <= sat_inc32(stat_correct);
      else                         stat_mispred <= sat_inc32(stat_mispred);
    end
  end

  assign bus.stat_correct_o = stat_correct;
  assign bus.stat_mispred_o = stat_mispred;
`else
  assign bus.stat_correct_o = '0;
  assign bus.stat_mispred_o = '0;
`endif
endmodule
